half_shell_pair_scheduler: RTL

HALF_SHELL_PAIR_SCHEDULER -- requirements
Module: half_shell_pair_scheduler

---
 rtl/half_shell_pair_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/half_shell_pair_scheduler.sv
// half_shell_pair_scheduler
// Sweeps every (home, neighbor) particle address pair of a half-shell cell
// group, broadcasting addresses to the position caches and presenting a
// per-slot valid vector aligned with the cache readout.
// Optional build macro: HOME_CELL_FILTER_EN -- when defined, slot 0 (the home
// cell) only flags pairs with n > h, suppressing self and duplicate pairs.
module half_shell_pair_scheduler #(
    parameter int unsigned PARTICLE_ID_WIDTH  = 7,
    parameter int unsigned NUM_NEIGHBOR_CELLS = 13,
    parameter int unsigned CACHE_RD_LATENCY   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [PARTICLE_ID_WIDTH-1:0]     home_count,
    input  logic [PARTICLE_ID_WIDTH-1:0]     nb_count,
    input  logic                             pe_ready,
    output logic [PARTICLE_ID_WIDTH-1:0]     rd_home_addr,
    output logic [PARTICLE_ID_WIDTH-1:0]     rd_nb_addr,
    output logic [NUM_NEIGHBOR_CELLS:0]      pe_valid,
    output logic [PARTICLE_ID_WIDTH-1:0]     pe_home_addr,
    output logic                             busy,
    output logic                             done,
    output logic [2*PARTICLE_ID_WIDTH-1:0]   pair_count
);

    localparam int unsigned PW      = PARTICLE_ID_WIDTH;
    localparam int unsigned SLOTS   = NUM_NEIGHBOR_CELLS + 1;
    localparam int unsigned CW      = 2 * PARTICLE_ID_WIDTH;
    localparam int unsigned LAT     = CACHE_RD_LATENCY;
    localparam int unsigned DRAIN_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_STALL = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [PW-1:0]          home_cnt;
    logic [PW-1:0]          nb_cnt;
    logic [DRAIN_W-1:0]     drain_cnt;

    logic [SLOTS-1:0]       v_pipe [LAT];
    logic [PW-1:0]          h_pipe [LAT];

    logic                   start_ok_c;
    logic                   empty_c;
    logic                   issue_c;
    logic                   n_last_c;
    logic                   h_last_c;
    logic                   last_pair_c;
    logic                   drain_last_c;
    logic                   slot0_keep_c;
    logic [SLOTS-1:0]       v_in_c;
    logic                   busy_d;
    logic                   done_d;

    // Shared decode of sweep position and handshake conditions
    always_comb begin
        start_ok_c   = (state == S_IDLE) && start;
        empty_c      = (home_count == '0) || (nb_count == '0);
        issue_c      = (state == S_ISSUE) && pe_ready;
        n_last_c     = (rd_nb_addr == (nb_cnt - PW'(1)));
        h_last_c     = (rd_home_addr == (home_cnt - PW'(1)));
        last_pair_c  = n_last_c && h_last_c;
        drain_last_c = (drain_cnt == DRAIN_W'(LAT - 1));
    end

`ifdef HOME_CELL_FILTER_EN
    // Home-cell slot keeps only the upper triangle of the pair matrix
    always_comb slot0_keep_c = (rd_nb_addr > rd_home_addr);
`else
    // Home-cell slot is flagged like every neighbor slot; PEs filter
    always_comb slot0_keep_c = 1'b1;
`endif

    // Valid vector entering the readout-alignment pipeline
    always_comb begin
        v_in_c    = {SLOTS{issue_c}};
        v_in_c[0] = issue_c & slot0_keep_c;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start_ok_c) next_state = empty_c ? S_DRAIN : S_ISSUE;
            S_ISSUE: begin
                if (!pe_ready)        next_state = S_STALL;
                else if (last_pair_c) next_state = S_DRAIN;
            end
            S_STALL: if (pe_ready)     next_state = S_ISSUE;
            S_DRAIN: if (drain_last_c) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done leave a flop
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (next_state)
            S_ISSUE, S_STALL, S_DRAIN: busy_d = 1'b1;
            S_DONE:                    done_d = 1'b1;
            default: ;
        endcase
    end

    // Status output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Sweep counters: latched counts, address pair walk, issue count, drain timer
    always_ff @(posedge clk) begin
        if (rst) begin
            home_cnt     <= '0;
            nb_cnt       <= '0;
            rd_home_addr <= '0;
            rd_nb_addr   <= '0;
            pair_count   <= '0;
            drain_cnt    <= '0;
        end else begin
            if (start_ok_c) begin
                home_cnt     <= home_count;
                nb_cnt       <= nb_count;
                rd_home_addr <= '0;
                rd_nb_addr   <= '0;
                pair_count   <= '0;
            end else if (issue_c) begin
                if (n_last_c) begin
                    rd_nb_addr   <= '0;
                    rd_home_addr <= h_last_c ? '0 : rd_home_addr + PW'(1);
                end else begin
                    rd_nb_addr   <= rd_nb_addr + PW'(1);
                end
                if (pair_count != {CW{1'b1}}) pair_count <= pair_count + CW'(1);
            end
            if (state == S_DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
            else                  drain_cnt <= '0;
        end
    end

    // Free-running alignment pipeline matching the cache read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                v_pipe[i] <= '0;
                h_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0] <= v_in_c;
            h_pipe[0] <= rd_home_addr;
            for (int unsigned i = 1; i < LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                h_pipe[i] <= h_pipe[i-1];
            end
        end
    end

    assign pe_valid     = v_pipe[LAT-1];
    assign pe_home_addr = h_pipe[LAT-1];

endmodule
